// File: rtl/data_mem_responder.sv
// MEM-stage data memory: posted store buffer draining into a word array, with load forwarding.
// Optional DMEM_RESPONDER_STATS_EN adds the FwdHits/FullDrains saturating counters.
module data_mem_responder #(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned SB_DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned PW = $clog2(SB_DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          MemoryRead,
  input  logic          MemoryWrite,
  input  logic [AW-1:0] Address,
  input  logic [31:0]   WriteData,
  output logic [31:0]   ReadData,
  input  logic          Flush,
  output logic          FlushDone,
  output logic [CW-1:0] SbCount,
  output logic          ReqErr
`ifdef DMEM_RESPONDER_STATS_EN
  ,
  output logic [15:0]   FwdHits,
  output logic [15:0]   FullDrains
`endif
);

  logic [31:0]   mem    [DEPTH];
  logic [AW-1:0] sbAddr [SB_DEPTH];
  logic [31:0]   sbData [SB_DEPTH];
  logic [SB_DEPTH-1:0] sbValid;
  logic [PW-1:0] sbHead, sbTail;
  logic [CW-1:0] sbCount;

  logic          fwdHit;
  logic [31:0]   fwdData;
  logic [PW-1:0] idx;
  logic          full, doDrain, doEnq;

  // Walk oldest to youngest so the last match (youngest store) wins.
  always_comb begin
    fwdHit  = 1'b0;
    fwdData = '0;
    idx     = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      idx = sbHead + PW'(i);
      if (sbValid[idx] && (sbAddr[idx] == Address)) begin
        fwdHit  = 1'b1;
        fwdData = sbData[idx];
      end
    end
  end

  assign ReadData  = MemoryRead ? (fwdHit ? fwdData : mem[Address]) : '0;
  assign full      = (sbCount == CW'(SB_DEPTH));
  // A full buffer must drain on a write so the enqueue never overflows.
  assign doDrain   = (sbCount != '0) && (!MemoryRead || (full && MemoryWrite) || Flush);
  assign doEnq     = MemoryWrite;
  assign FlushDone = Flush && (sbCount == '0);
  assign SbCount   = sbCount;

  always_ff @(negedge CLK or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      sbValid <= '0;
      sbHead  <= '0;
      sbTail  <= '0;
      sbCount <= '0;
      ReqErr  <= 1'b0;
    end else begin
      if (doDrain) begin
        mem[sbAddr[sbHead]] <= sbData[sbHead];
        sbValid[sbHead]     <= 1'b0;
        sbHead              <= sbHead + PW'(1);
      end
      // Placed after the drain so a full-buffer slot reuse stays valid.
      if (doEnq) begin
        sbValid[sbTail] <= 1'b1;
        sbTail          <= sbTail + PW'(1);
      end
      if (doEnq && !doDrain) begin
        sbCount <= sbCount + CW'(1);
      end else if (doDrain && !doEnq) begin
        sbCount <= sbCount - CW'(1);
      end
      ReqErr <= MemoryRead && MemoryWrite;
    end
  end

  always_ff @(negedge CLK) begin
    if (doEnq) begin
      sbAddr[sbTail] <= Address;
      sbData[sbTail] <= WriteData;
    end
  end

`ifdef DMEM_RESPONDER_STATS_EN
  always_ff @(negedge CLK or posedge Reset) begin
    if (Reset) begin
      FwdHits    <= '0;
      FullDrains <= '0;
    end else begin
      if (MemoryRead && fwdHit && (FwdHits != 16'hFFFF)) FwdHits <= FwdHits + 16'd1;
      if (full && MemoryWrite && (FullDrains != 16'hFFFF)) FullDrains <= FullDrains + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed table-driven bench for data_mem_responder (falling-edge state, combinational read path).
module tb_data_mem_responder;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        MemoryRead, MemoryWrite, Flush;
  logic [5:0]  Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        FlushDone;
  logic [2:0]  SbCount;
  logic        ReqErr;
`ifdef DMEM_RESPONDER_STATS_EN
  logic [15:0] FwdHits, FullDrains;
`endif

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  data_mem_responder dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .MemoryRead (MemoryRead),
    .MemoryWrite(MemoryWrite),
    .Address    (Address),
    .WriteData  (WriteData),
    .ReadData   (ReadData),
    .Flush      (Flush),
    .FlushDone  (FlushDone),
    .SbCount    (SbCount),
    .ReqErr     (ReqErr)
`ifdef DMEM_RESPONDER_STATS_EN
    ,
    .FwdHits    (FwdHits),
    .FullDrains (FullDrains)
`endif
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [5:0]  a;
    logic [31:0] d;
    logic        fl;
    logic [31:0] expRd;
    logic [2:0]  expCnt;
    logic        expErr;
    logic        expFd;
  } vec_t;

  vec_t vecs [29];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Inputs change just after the rising edge; outputs are checked before the falling edge.
  task automatic drive(input logic rd, input logic wr, input logic [5:0] a,
                       input logic [31:0] d, input logic fl);
    @(posedge CLK);
    #1;
    MemoryRead  = rd;
    MemoryWrite = wr;
    Address     = a;
    WriteData   = d;
    Flush       = fl;
    #2;
  endtask

  initial begin
    vecs[0]  = '{0, 1, 6'd5, 32'hDEADBEEF, 0, 32'h0,        3'd0, 0, 0};
    vecs[1]  = '{1, 0, 6'd5, 32'h0,        0, 32'hDEADBEEF, 3'd1, 0, 0};
    vecs[2]  = '{0, 0, 6'd0, 32'h0,        0, 32'h0,        3'd1, 0, 0};
    vecs[3]  = '{1, 0, 6'd5, 32'h0,        0, 32'hDEADBEEF, 3'd0, 0, 0};
    vecs[4]  = '{0, 1, 6'd3, 32'h1,        0, 32'h0,        3'd0, 0, 0};
    vecs[5]  = '{0, 1, 6'd3, 32'h2,        0, 32'h0,        3'd1, 0, 0};
    vecs[6]  = '{1, 0, 6'd3, 32'h0,        0, 32'h2,        3'd1, 0, 0};
    vecs[7]  = '{0, 0, 6'd0, 32'h0,        0, 32'h0,        3'd1, 0, 0};
    vecs[8]  = '{1, 0, 6'd3, 32'h0,        0, 32'h2,        3'd0, 0, 0};
    vecs[9]  = '{1, 1, 6'd0, 32'h100,      0, 32'h0,        3'd0, 0, 0};
    vecs[10] = '{1, 1, 6'd1, 32'h101,      0, 32'h0,        3'd1, 1, 0};
    vecs[11] = '{1, 1, 6'd2, 32'h102,      0, 32'h0,        3'd2, 1, 0};
    vecs[12] = '{1, 1, 6'd3, 32'h103,      0, 32'h2,        3'd3, 1, 0};
    vecs[13] = '{1, 1, 6'd4, 32'h104,      0, 32'h0,        3'd4, 1, 0};
    vecs[14] = '{1, 0, 6'd0, 32'h0,        0, 32'h100,      3'd4, 1, 0};
    vecs[15] = '{1, 0, 6'd2, 32'h0,        0, 32'h102,      3'd4, 0, 0};
    vecs[16] = '{0, 0, 6'd0, 32'h0,        0, 32'h0,        3'd4, 0, 0};
    vecs[17] = '{1, 0, 6'd4, 32'h0,        1, 32'h104,      3'd3, 0, 0};
    vecs[18] = '{1, 0, 6'd4, 32'h0,        1, 32'h104,      3'd2, 0, 0};
    vecs[19] = '{1, 0, 6'd4, 32'h0,        1, 32'h104,      3'd1, 0, 0};
    vecs[20] = '{1, 0, 6'd4, 32'h0,        1, 32'h104,      3'd0, 0, 1};
    vecs[21] = '{1, 0, 6'd4, 32'h0,        0, 32'h104,      3'd0, 0, 0};
    vecs[22] = '{1, 1, 6'd7, 32'h55,       0, 32'h0,        3'd0, 0, 0};
    vecs[23] = '{1, 0, 6'd7, 32'h0,        0, 32'h55,       3'd1, 1, 0};
    vecs[24] = '{1, 0, 6'd7, 32'h0,        0, 32'h55,       3'd1, 0, 0};
    vecs[25] = '{1, 1, 6'd9, 32'h11,       0, 32'h0,        3'd1, 0, 0};
    vecs[26] = '{1, 1, 6'd9, 32'h22,       0, 32'h11,       3'd2, 1, 0};
    vecs[27] = '{1, 0, 6'd9, 32'h0,        0, 32'h22,       3'd3, 1, 0};
    vecs[28] = '{0, 0, 6'd0, 32'h0,        0, 32'h0,        3'd3, 0, 0};

    Reset = 1'b1;
    MemoryRead = 1'b1; MemoryWrite = 1'b0; Address = 6'd5; WriteData = '0; Flush = 1'b1;
    #2;
    check("reset_sbcount",   32'(SbCount),   32'd0);
    check("reset_reqerr",    32'(ReqErr),    32'd0);
    check("reset_readdata",  ReadData,       32'd0);
    check("reset_flushdone", 32'(FlushDone), 32'd1);
    Flush = 1'b0;
    #1;
    check("reset_flushdone_low", 32'(FlushDone), 32'd0);
    #10;
    Reset = 1'b0;

    for (int i = 0; i < 29; i++) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].fl);
      check($sformatf("v%0d_readdata", i),  ReadData,            vecs[i].expRd);
      check($sformatf("v%0d_sbcount", i),   32'(SbCount),        32'(vecs[i].expCnt));
      check($sformatf("v%0d_reqerr", i),    32'(ReqErr),         32'(vecs[i].expErr));
      check($sformatf("v%0d_flushdone", i), 32'(FlushDone),      32'(vecs[i].expFd));
    end

    // Drained store at 7 now comes from the array.
    drive(1, 0, 6'd7, 32'h0, 0);
    check("array7_readdata", ReadData, 32'h55);
    check("array7_sbcount", 32'(SbCount), 32'd2);

    // Build three pending stores, then reset mid-cycle.
    drive(1, 1, 6'd10, 32'h77, 0);
    check("pre_reset_readdata", ReadData, 32'h0);
    @(negedge CLK);
    #1;
    check("pre_reset_sbcount", 32'(SbCount), 32'd3);
    check("pre_reset_reqerr",  32'(ReqErr),  32'd1);
`ifdef DMEM_RESPONDER_STATS_EN
    check("stats_fwdhits",    32'(FwdHits),    32'd10);
    check("stats_fulldrains", 32'(FullDrains), 32'd1);
`endif
    MemoryWrite = 1'b0;
    MemoryRead  = 1'b1;
    Address     = 6'd9;
    Reset       = 1'b1;
    #1;
    check("midreset_sbcount",  32'(SbCount), 32'd0);
    check("midreset_reqerr",   32'(ReqErr),   32'd0);
    check("midreset_readdata", ReadData,      32'd0);
`ifdef DMEM_RESPONDER_STATS_EN
    check("midreset_fwdhits", 32'(FwdHits), 32'd0);
`endif
    #1;
    Reset = 1'b0;

    drive(1, 0, 6'd9, 32'h0, 0);
    check("post_reset_read9", ReadData, 32'h0);
    drive(1, 0, 6'd10, 32'h0, 0);
    check("post_reset_read10", ReadData, 32'h0);
    drive(1, 0, 6'd5, 32'h0, 0);
    check("post_reset_read5", ReadData, 32'h0);
    check("post_reset_sbcount", 32'(SbCount), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder for the pipelined MIPS core's MEM stage.
- Accepts the core's MemoryRead/MemoryWrite/Address/WriteData requests and returns ReadData within the same cycle.
- Stores are posted into a small store buffer that drains into a single-port word array when the array is idle.
- Reads forward from the store buffer so the core always sees program-order data; the core never stalls on memory.

Parameters:
- DEPTH, 64, number of 32-bit words in the array; address width is $clog2(DEPTH).
- SB_DEPTH, 4, store-buffer entries (power of two, 2..8).

Ports:
- CLK  input  1  clock; all state updates on the falling edge, matching the pipeline registers.
- Reset  input  1  asynchronous, active-high reset.
- MemoryRead  input  1  read request this cycle.
- MemoryWrite  input  1  write request this cycle.
- Address  input  6  word index (log2 DEPTH bits).
- WriteData  input  32  store data.
- ReadData  output  32  load data, combinational, valid in the request cycle.
- Flush  input  1  level: force drain every cycle until empty.
- FlushDone  output  1  high when Flush=1 and buffer empty.
- SbCount  output  $clog2(SB_DEPTH)+1  occupied entries.
- ReqErr  output  1  registered one-cycle pulse on illegal request.

Behaviour:
- Reset (async): array cleared to 0; buffer head/tail/count = 0; all entry valid bits = 0; ReqErr = 0; SbCount = 0. Outputs then read: ReadData = 0, FlushDone = Flush.
- Storage: array of DEPTH×32 words; circular store buffer of {addr, data} entries with head (oldest) and tail pointers that wrap modulo SB_DEPTH.
- Read path (combinational):
  - With MemoryRead=1, ReadData = data of the youngest buffer entry whose addr == Address.
  - If no entry matches, ReadData = array[Address].
  - With MemoryRead=0, ReadData = 0.
- Drain (falling edge): head entry written to array[addr], head++, count--. A drain occurs when count>0 and any of the following holds:
  - MemoryRead=0 (array port free);
  - count==SB_DEPTH and MemoryWrite=1 (full-buffer write);
  - Flush=1.
- Enqueue (falling edge): MemoryWrite=1 writes {Address, WriteData} at tail, tail++, count++.
- Simultaneous drain and enqueue: both happen in the same edge; count is unchanged; the full buffer therefore never overflows.
- Read while the buffer is full and MemoryWrite=0: no drain that cycle; the read still returns forwarded data.
- Duplicate addresses in the buffer are allowed; drain order preserves program order, so the last store wins in the array.
- MemoryRead=1 and MemoryWrite=1 in the same cycle is illegal:
  - the write is still enqueued;
  - ReadData reflects state before the write;
  - ReqErr pulses high the next cycle.
- FlushDone = Flush & (count==0), combinational.
- Latency: store-to-load forwarding is 0 cycles; buffered data reaches the array no later than SB_DEPTH idle cycles after enqueue.
- Address bits at or above log2(DEPTH) are ignored.
- Reset mid-operation discards all buffered stores; they are not drained.

Optional Feature:
- Macro: DMEM_RESPONDER_STATS_EN.
- Defined:
  - adds output FwdHits [15:0], counting cycles where MemoryRead=1 and a buffer match supplied ReadData;
  - adds output FullDrains [15:0], counting full-buffer writes;
  - both counters saturate at 16'hFFFF and clear on Reset.
- Undefined: neither port exists and no counter logic is synthesized; all other behaviour is identical.

Test Plan:
- Reset with Reset=1 mid-run holding 3 buffered stores -> SbCount=0, ReqErr=0; read of a previously stored address returns 0.
- Write addr 5 = 32'hDEADBEEF, then read addr 5 on the very next cycle -> ReadData=32'hDEADBEEF (forwarded); SbCount=1 during the read. One idle cycle later -> array[5]=32'hDEADBEEF and SbCount=0.
- Writes addr 3 = 1 then addr 3 = 2 back-to-back, then a read of addr 3 -> ReadData=2; after draining, array[3]=2.
- 4 writes to addrs 0..3 with MemoryRead held high so nothing drains (SbCount=4), then a 5th write to addr 4 -> addr 0 drains the same edge, SbCount stays 4; with STATS, FullDrains=1.
- Assert Flush with 3 entries pending and MemoryRead=1 held -> SbCount decrements 3,2,1,0 on successive edges; FlushDone rises when count reaches 0.
- MemoryRead=1 and MemoryWrite=1 together at addr 7 = 32'h55 -> ReadData=old array[7] (0); ReqErr=1 for exactly one cycle; a subsequent read of addr 7 returns 32'h55.
